// File: rtl/db_target_resp.sv
// Target endpoint of the doorbell/NWR self-check flow.
// It answers ready-query doorbells on tresp and strips NWR headers toward the user write sink.
module db_target_resp #(
  parameter logic [15:0] LOCAL_ID   = 16'h00F0,
  parameter logic [15:0] QUERY_INFO = 16'h0101,
  parameter logic [15:0] READY_INFO = 16'h0100,
  parameter logic [15:0] BUSY_INFO  = 16'h01FF
) (
  input  logic        log_clk,
  input  logic        log_rst,
  input  logic        link_initialized,
  input  logic        treq_tvalid_in,
  output logic        treq_tready_o,
  input  logic        treq_tlast_in,
  input  logic [63:0] treq_tdata_in,
  input  logic [7:0]  treq_tkeep_in,
  input  logic [31:0] treq_tuser_in,
  output logic        tresp_tvalid_o,
  input  logic        tresp_tready_in,
  output logic        tresp_tlast_o,
  output logic [63:0] tresp_tdata_o,
  output logic [7:0]  tresp_tkeep_o,
  output logic [31:0] tresp_tuser_o,
  output logic        user_rx_tvalid_o,
  input  logic        user_rx_tready_in,
  output logic [63:0] user_rx_tdata_o,
  output logic [7:0]  user_rx_tkeep_o,
  output logic        user_rx_tlast_o,
  output logic [33:0] user_rx_addr_o,
  output logic [15:0] nwr_pkt_cnt_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, DB_RESP, NWR_DATA, DROP} state_t;

  state_t      state_q;
  logic [5:0]  beats_q;
  logic [5:0]  beat_cnt_q;
  logic [33:0] addr_q;
  logic [15:0] pkt_cnt_q;
  logic        err_q;
  logic        tresp_valid_q;
  logic [63:0] tresp_data_q;
  logic [31:0] tresp_user_q;

  logic [7:0]  hdr_tid;
  logic [3:0]  hdr_ftype;
  logic [3:0]  hdr_ttype;
  logic [1:0]  hdr_prio;
  logic [7:0]  hdr_size;
  logic [15:0] hdr_info;
  logic        treq_accept;
  logic        is_query;
  logic        is_nwr;
  logic        overrun;
  logic [5:0]  beat_num_d;
  logic [5:0]  beats_d;
  logic [1:0]  resp_prio_d;
  logic [15:0] resp_info_d;
  logic        unused_tuser;

  assign hdr_tid   = treq_tdata_in[63:56];
  assign hdr_ftype = treq_tdata_in[55:52];
  assign hdr_ttype = treq_tdata_in[51:48];
  assign hdr_prio  = treq_tdata_in[46:45];
  assign hdr_size  = treq_tdata_in[43:36];
  assign hdr_info  = treq_tdata_in[31:16];

  assign unused_tuser = ^treq_tuser_in[15:0];

  assign treq_accept = treq_tvalid_in && treq_tready_o;
  assign is_query    = (hdr_ftype == 4'hA) && (hdr_info == QUERY_INFO) && treq_tlast_in;
  assign is_nwr      = (hdr_ftype == 4'h5) && (hdr_ttype == 4'h4) && !treq_tlast_in;
  assign beats_d     = {1'b0, hdr_size[7:3]} + 6'd1;
  assign beat_num_d  = beat_cnt_q + 6'd1;
  assign resp_prio_d = hdr_prio + 2'd1;
  assign resp_info_d = user_rx_tready_in ? READY_INFO : BUSY_INFO;

  // Every expected beat already transferred: further beats are swallowed, not forwarded.
  assign overrun = (state_q == NWR_DATA) && (beat_cnt_q == beats_q);

  always_comb begin
    treq_tready_o    = 1'b0;
    user_rx_tvalid_o = 1'b0;
    user_rx_tdata_o  = 64'h0;
    user_rx_tkeep_o  = 8'h0;
    user_rx_tlast_o  = 1'b0;
    unique case (state_q)
      IDLE:     treq_tready_o = link_initialized;
      DB_RESP:  treq_tready_o = 1'b0;
      NWR_DATA: begin
        if (overrun) begin
          treq_tready_o = 1'b1;
        end else begin
          treq_tready_o    = user_rx_tready_in;
          user_rx_tvalid_o = treq_tvalid_in;
          user_rx_tdata_o  = treq_tdata_in;
          user_rx_tkeep_o  = treq_tkeep_in;
          user_rx_tlast_o  = treq_tlast_in;
        end
      end
      DROP:     treq_tready_o = 1'b1;
      default:  treq_tready_o = 1'b0;
    endcase
  end

  always_ff @(posedge log_clk or posedge log_rst) begin
    if (log_rst) begin
      state_q       <= IDLE;
      beats_q       <= 6'd0;
      beat_cnt_q    <= 6'd0;
      addr_q        <= 34'h0;
      pkt_cnt_q     <= 16'h0;
      err_q         <= 1'b0;
      tresp_valid_q <= 1'b0;
      tresp_data_q  <= 64'h0;
      tresp_user_q  <= 32'h0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (treq_accept) begin
            if (is_query) begin
              tresp_valid_q <= 1'b1;
              tresp_data_q  <= {hdr_tid, 4'hA, 4'h0, 1'b0, resp_prio_d, 1'b0,
                                12'h0, resp_info_d, 16'h0};
              tresp_user_q  <= {LOCAL_ID, treq_tuser_in[31:16]};
              state_q       <= DB_RESP;
            end else if (is_nwr) begin
              addr_q     <= treq_tdata_in[33:0];
              beats_q    <= beats_d;
              beat_cnt_q <= 6'd0;
              state_q    <= NWR_DATA;
            end else begin
              err_q   <= 1'b1;
              state_q <= treq_tlast_in ? IDLE : DROP;
            end
          end
        end
        DB_RESP: begin
          if (tresp_tready_in) begin
            tresp_valid_q <= 1'b0;
            tresp_data_q  <= 64'h0;
            tresp_user_q  <= 32'h0;
            state_q       <= IDLE;
          end
        end
        NWR_DATA: begin
          if (treq_accept) begin
            if (overrun) begin
              err_q   <= 1'b1;
              state_q <= treq_tlast_in ? IDLE : DROP;
            end else begin
              beat_cnt_q <= beat_num_d;
              if (treq_tlast_in) begin
                if (beat_num_d == beats_q) begin
                  pkt_cnt_q <= pkt_cnt_q + 16'd1;
                end else begin
                  err_q <= 1'b1;
                end
                state_q <= IDLE;
              end
            end
          end
        end
        DROP: begin
          if (treq_accept && treq_tlast_in) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tresp_tvalid_o = tresp_valid_q;
  assign tresp_tlast_o  = tresp_valid_q;
  assign tresp_tkeep_o  = {8{tresp_valid_q}};
  assign tresp_tdata_o  = tresp_data_q;
  assign tresp_tuser_o  = tresp_user_q;
  assign user_rx_addr_o = addr_q;
  assign nwr_pkt_cnt_o  = pkt_cnt_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_db_target_resp.sv
// Scoreboard bench for db_target_resp: packet-level reference model pushes expectations,
// a negedge monitor pops and compares on every tresp / user_rx handshake.
`timescale 1ns/1ps
module tb_db_target_resp;

  logic        log_clk = 1'b0;
  logic        log_rst = 1'b1;
  logic        link_initialized = 1'b0;
  logic        treq_tvalid_in = 1'b0;
  logic        treq_tready_o;
  logic        treq_tlast_in = 1'b0;
  logic [63:0] treq_tdata_in = 64'h0;
  logic [7:0]  treq_tkeep_in = 8'h0;
  logic [31:0] treq_tuser_in = 32'h0;
  logic        tresp_tvalid_o;
  logic        tresp_tready_in = 1'b0;
  logic        tresp_tlast_o;
  logic [63:0] tresp_tdata_o;
  logic [7:0]  tresp_tkeep_o;
  logic [31:0] tresp_tuser_o;
  logic        user_rx_tvalid_o;
  logic        user_rx_tready_in = 1'b1;
  logic [63:0] user_rx_tdata_o;
  logic [7:0]  user_rx_tkeep_o;
  logic        user_rx_tlast_o;
  logic [33:0] user_rx_addr_o;
  logic [15:0] nwr_pkt_cnt_o;
  logic        err_o;

  always #5 log_clk = ~log_clk;

  db_target_resp dut (
    .log_clk(log_clk), .log_rst(log_rst), .link_initialized(link_initialized),
    .treq_tvalid_in(treq_tvalid_in), .treq_tready_o(treq_tready_o),
    .treq_tlast_in(treq_tlast_in), .treq_tdata_in(treq_tdata_in),
    .treq_tkeep_in(treq_tkeep_in), .treq_tuser_in(treq_tuser_in),
    .tresp_tvalid_o(tresp_tvalid_o), .tresp_tready_in(tresp_tready_in),
    .tresp_tlast_o(tresp_tlast_o), .tresp_tdata_o(tresp_tdata_o),
    .tresp_tkeep_o(tresp_tkeep_o), .tresp_tuser_o(tresp_tuser_o),
    .user_rx_tvalid_o(user_rx_tvalid_o), .user_rx_tready_in(user_rx_tready_in),
    .user_rx_tdata_o(user_rx_tdata_o), .user_rx_tkeep_o(user_rx_tkeep_o),
    .user_rx_tlast_o(user_rx_tlast_o), .user_rx_addr_o(user_rx_addr_o),
    .nwr_pkt_cnt_o(nwr_pkt_cnt_o), .err_o(err_o)
  );

  typedef struct packed {logic [63:0] data; logic [31:0] user;} resp_t;
  typedef struct packed {logic [63:0] data; logic [7:0] keep; logic last; logic [33:0] addr;} ubeat_t;

  resp_t       resp_q[$];
  ubeat_t      user_q[$];
  resp_t       mon_r;
  ubeat_t      mon_u;
  int          checks = 0;
  int          failures = 0;
  int          exp_err = 0;
  int          obs_err = 0;
  logic [15:0] exp_pkt = 16'h0;
  bit          rand_tresp = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: a handshake seen at the negedge completes on the following posedge.
  always @(negedge log_clk) begin
    if (!log_rst) begin
      if (err_o) obs_err++;
      if (tresp_tvalid_o && tresp_tready_in) begin
        if (resp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL tresp_unexpected actual=%h required=none", tresp_tdata_o);
        end else begin
          mon_r = resp_q.pop_front();
          check("tresp_data", tresp_tdata_o, mon_r.data);
          check("tresp_user", {32'h0, tresp_tuser_o}, {32'h0, mon_r.user});
          check("tresp_last_keep", {55'h0, tresp_tlast_o, tresp_tkeep_o}, 64'h1FF);
        end
      end
      if (user_rx_tvalid_o && user_rx_tready_in) begin
        if (user_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL user_unexpected actual=%h required=none", user_rx_tdata_o);
        end else begin
          mon_u = user_q.pop_front();
          check("user_data", user_rx_tdata_o, mon_u.data);
          check("user_keep_last", {55'h0, user_rx_tkeep_o, user_rx_tlast_o},
                {55'h0, mon_u.keep, mon_u.last});
          check("user_addr", {30'h0, user_rx_addr_o}, {30'h0, mon_u.addr});
        end
      end
    end
  end

  initial forever begin
    @(posedge log_clk); #1;
    if (rand_tresp) tresp_tready_in = ($urandom_range(0, 3) != 0);
  end

  function automatic logic [63:0] db_hdr(input logic [7:0] tid, input logic [1:0] prio,
                                         input logic [15:0] info);
    return {tid, 4'hA, 4'h0, 1'b0, prio, 1'b0, 12'h0, info, 16'h0};
  endfunction

  function automatic logic [63:0] nwr_hdr(input logic [7:0] tid, input logic [1:0] prio,
                                          input logic [7:0] size, input logic [33:0] addr);
    return {tid, 4'h5, 4'h4, 1'b0, prio, 1'b0, size, 2'b00, addr};
  endfunction

  // Reference answer from field values: TID, ftype A, priority one above request, info.
  function automatic logic [63:0] exp_db(input int tid, input int prio, input bit rdy);
    logic [63:0] w;
    w = 64'(tid) << 56;
    w = w | (64'hA << 52);
    w = w | (64'((prio + 1) % 4) << 45);
    w = w | (64'(rdy ? 32'h0100 : 32'h01FF) << 16);
    return w;
  endfunction

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                           input bit rand_sink);
    int n;
    bit ok;
    repeat ($urandom_range(0, 1)) begin
      treq_tvalid_in = 1'b0;
      @(posedge log_clk); #1;
    end
    treq_tvalid_in = 1'b1;
    treq_tdata_in  = d;
    treq_tkeep_in  = k;
    treq_tlast_in  = l;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 300) begin
      if (rand_sink) user_rx_tready_in = ($urandom_range(0, 3) != 0);
      @(negedge log_clk);
      if (treq_tready_o) ok = 1'b1;
      @(posedge log_clk); #1;
      n++;
    end
    treq_tvalid_in = 1'b0;
    treq_tlast_in  = 1'b0;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL beat_accept_timeout actual=stalled required=accepted");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((resp_q.size() != 0 || user_q.size() != 0) && n < 500) begin
      @(posedge log_clk); #1;
      n++;
    end
    repeat (3) @(posedge log_clk);
    #1;
    check("queues_empty", 64'(resp_q.size() + user_q.size()), 64'h0);
    check("err_count", 64'(obs_err), 64'(exp_err));
    check("pkt_cnt", {48'h0, nwr_pkt_cnt_o}, {48'h0, exp_pkt});
  endtask

  task automatic do_query(input logic [7:0] tid, input logic [1:0] prio,
                          input logic [15:0] src, input bit rdy);
    user_rx_tready_in = rdy;
    treq_tuser_in     = {src, 16'h00F0};
    resp_q.push_back('{data: exp_db(int'(tid), int'(prio), rdy),
                       user: (32'h00F0 << 16) | 32'(src)});
    $display("TXN query tid=%h prio=%0d src=%h sink_ready=%0d", tid, prio, src, rdy);
    send_beat(db_hdr(tid, prio, 16'h0101), 8'hFF, 1'b1, 1'b0);
  endtask

  // send_n == size/8+1 is a good packet; fewer beats means an early tlast.
  task automatic do_nwr(input logic [7:0] size, input logic [33:0] addr, input int send_n);
    int beats;
    logic [63:0] d;
    logic [7:0]  k;
    beats = int'(size) / 8 + 1;
    if (send_n == beats) exp_pkt = exp_pkt + 16'd1;
    else exp_err++;
    $display("TXN nwr size=%h addr=%h beats=%0d sent=%0d", size, addr, beats, send_n);
    send_beat(nwr_hdr(8'($urandom), 2'($urandom), size, addr), 8'hFF, 1'b0, 1'b0);
    for (int i = 1; i <= send_n; i++) begin
      d = {$urandom, $urandom};
      k = 8'($urandom);
      user_q.push_back('{data: d, keep: k, last: (i == send_n), addr: addr});
      send_beat(d, k, (i == send_n), 1'b1);
    end
  endtask

  task automatic do_bad(input logic [63:0] hdr, input int len);
    exp_err++;
    $display("TXN bad hdr=%h len=%0d", hdr, len);
    send_beat(hdr, 8'hFF, (len == 1), 1'b1);
    for (int i = 2; i <= len; i++) send_beat({$urandom, $urandom}, 8'hFF, (i == len), 1'b1);
  endtask

  initial begin
    logic [63:0] held;
    logic [7:0]  sz;
    logic [3:0]  ft;
    logic [15:0] info;
    int          kind;
    int          n;

    repeat (3) @(posedge log_clk);
    #1;
    check("rst_tresp_valid", {63'h0, tresp_tvalid_o}, 64'h0);
    check("rst_user_valid", {63'h0, user_rx_tvalid_o}, 64'h0);
    check("rst_err_cnt", {47'h0, err_o, nwr_pkt_cnt_o}, 64'h0);
    check("rst_addr", {30'h0, user_rx_addr_o}, 64'h0);
    log_rst = 1'b0;
    @(posedge log_clk); #1;

    // Link down: header presented but never accepted.
    treq_tvalid_in = 1'b1;
    treq_tlast_in  = 1'b1;
    treq_tdata_in  = db_hdr(8'h11, 2'd0, 16'h0101);
    repeat (4) begin
      @(negedge log_clk);
      check("link_down_tready", {63'h0, treq_tready_o}, 64'h0);
    end
    @(posedge log_clk); #1;
    treq_tvalid_in = 1'b0;
    treq_tlast_in  = 1'b0;
    check("link_down_no_tresp", {63'h0, tresp_tvalid_o}, 64'h0);
    link_initialized = 1'b1;

    // Directed ready query with literal expectation.
    user_rx_tready_in = 1'b1;
    treq_tuser_in     = 32'h0001_00F0;
    resp_q.push_back('{data: 64'h5AA0_4000_0100_0000, user: 32'h00F0_0001});
    $display("TXN query directed ready");
    send_beat(db_hdr(8'h5A, 2'd1, 16'h0101), 8'hFF, 1'b1, 1'b0);
    drain();

    // Busy query with the core back-pressuring tresp for 5 cycles.
    rand_tresp      = 1'b0;
    tresp_tready_in = 1'b0;
    user_rx_tready_in = 1'b0;
    resp_q.push_back('{data: 64'h5AA0_4000_01FF_0000, user: 32'h00F0_0001});
    $display("TXN query directed busy");
    send_beat(db_hdr(8'h5A, 2'd1, 16'h0101), 8'hFF, 1'b1, 1'b0);
    n = 0;
    while (!tresp_tvalid_o && n < 20) begin
      @(posedge log_clk); #1;
      n++;
    end
    check("busy_tresp_valid", {63'h0, tresp_tvalid_o}, 64'h1);
    held = tresp_tdata_o;
    repeat (5) begin
      @(posedge log_clk); #1;
      check("busy_tresp_held", {tresp_tdata_o[63:1], tresp_tvalid_o}, {held[63:1], 1'b1});
    end
    tresp_tready_in = 1'b1;
    @(posedge log_clk); #1;
    tresp_tready_in = 1'b0;
    repeat (2) @(posedge log_clk);
    #1;
    check("busy_single_accept", {63'h0, tresp_tvalid_o}, 64'h0);
    rand_tresp = 1'b1;
    drain();

    // Maximum-size NWR, then an early-tlast NWR, then a foreign 3-beat packet.
    do_nwr(8'hFF, 34'h0_0010_0000, 32);
    drain();
    do_nwr(8'h0F, 34'h0_0000_1234, 1);
    drain();
    do_bad({8'h01, 4'h2, 4'h0, 56'h0}, 3);
    drain();

    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 3);
      sz   = 8'($urandom);
      case (kind)
        0: do_query(8'($urandom), 2'($urandom), 16'($urandom), 1'($urandom));
        1: do_nwr(sz, 34'({$urandom, $urandom}), int'(sz) / 8 + 1);
        2: begin
          if (sz < 8'd8) sz = sz + 8'd8;
          do_nwr(sz, 34'({$urandom, $urandom}), $urandom_range(1, int'(sz) / 8));
        end
        default: begin
          case ($urandom_range(0, 2))
            0: begin
              do ft = 4'($urandom); while (ft == 4'hA || ft == 4'h5);
              do_bad({8'($urandom), ft, 52'($urandom)}, $urandom_range(1, 3));
            end
            1: begin
              do info = 16'($urandom); while (info == 16'h0101);
              do_bad(db_hdr(8'($urandom), 2'($urandom), info), $urandom_range(1, 2));
            end
            default: do_bad(nwr_hdr(8'($urandom), 2'd0, sz, 34'h100), 1);
          endcase
        end
      endcase
      drain();
    end

    // Reset in the middle of a maximum-size NWR.
    user_rx_tready_in = 1'b1;
    $display("TXN nwr interrupted by reset");
    send_beat(nwr_hdr(8'h22, 2'd0, 8'hFF, 34'h0_0010_0000), 8'hFF, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      held = {$urandom, $urandom};
      user_q.push_back('{data: held, keep: 8'hFF, last: 1'b0, addr: 34'h0_0010_0000});
      send_beat(held, 8'hFF, 1'b0, 1'b0);
    end
    user_rx_tready_in = 1'b1;
    treq_tvalid_in = 1'b1;
    treq_tdata_in  = 64'hDEAD_BEEF_0000_000B;
    treq_tkeep_in  = 8'hFF;
    #1;
    check("pre_rst_passthru", {63'h0, user_rx_tvalid_o}, 64'h1);
    #2;
    log_rst = 1'b1;
    #1;
    check("midrst_user_valid", {63'h0, user_rx_tvalid_o}, 64'h0);
    check("midrst_user_data", user_rx_tdata_o, 64'h0);
    check("midrst_cnt_addr", {14'h0, nwr_pkt_cnt_o, user_rx_addr_o}, 64'h0);
    check("midrst_tresp_err", {62'h0, tresp_tvalid_o, err_o}, 64'h0);
    treq_tvalid_in = 1'b0;
    user_q.delete();
    resp_q.delete();
    exp_pkt = 16'h0;
    exp_err = 0;
    obs_err = 0;
    repeat (2) @(posedge log_clk);
    #1;
    log_rst = 1'b0;
    @(posedge log_clk); #1;
    do_query(8'h33, 2'd3, 16'h0042, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
